tx_rx_sequencer: RTL and testbench

Timed transmit/receive sequencer between the SPI register block and the RF hardware. It takes raw requests from the STM32 over SPI (TX request, band, NCO enable) and drives the PIN-diode band-select and TX/RX switch lines and the NCO enable. Its job is to guarantee the Class E PA never sees RF drive while a PIN switch or band filter is changing state. It runs on the 100 MHz system clock.

---
 rtl/nexrig_pkg.sv | 8 +
 rtl/tx_rx_sequencer_if.sv | 15 +
 rtl/tx_rx_sequencer_settle_timer.sv | 18 +
 rtl/tx_rx_sequencer.sv | 92 +++++++++
 tb/tb_tx_rx_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/nexrig_pkg.sv
// nexrig_pkg: shared sequencer state type, band width and default settle times
package nexrig_pkg;
  localparam int BAND_W = 8;
  localparam int BAND_SETTLE_DEF = 1000;
  localparam int PIN_SETTLE_DEF = 500;
  localparam int RF_DRAIN_DEF = 200;
  typedef enum logic [2:0] {RX_IDLE, BAND_SETTLE, TX_KEYUP, TX_ON, RF_DRAIN, TX_KEYDOWN} seqState_t;
endpackage

// File: rtl/tx_rx_sequencer_if.sv
// tx_rx_sequencer_if: SPI request inputs and RF control outputs of the sequencer
interface tx_rx_sequencer_if;
  import nexrig_pkg::*;
  logic txReq;
  logic [BAND_W-1:0] bandReq;
  logic ncoEnableReq;
  logic [BAND_W-1:0] bandSelect;
  logic txEnable;
  logic ncoEnable;
  logic busy;
  logic txActive;
  logic bandFault;
  modport master(output txReq, bandReq, ncoEnableReq, input bandSelect, txEnable, ncoEnable, busy, txActive, bandFault);
  modport slave(input txReq, bandReq, ncoEnableReq, output bandSelect, txEnable, ncoEnable, busy, txActive, bandFault);
endinterface

// File: rtl/tx_rx_sequencer_settle_timer.sv
// settle_timer: loadable down-counter, expired while the count reads zero
module settle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/tx_rx_sequencer.sv
// tx_rx_sequencer: timed TX/RX and band switching that keeps RF drive off while PIN switches settle
module tx_rx_sequencer
  import nexrig_pkg::*;
#(
  parameter int BAND_SETTLE_CYC = BAND_SETTLE_DEF,
  parameter int PIN_SETTLE_CYC  = PIN_SETTLE_DEF,
  parameter int RF_DRAIN_CYC    = RF_DRAIN_DEF,
  parameter int CNT_W           = 16
) (
  input logic              clk,
  input logic              rst,
  tx_rx_sequencer_if.slave sif
);
  seqState_t state;
  logic load, expired, band_ok, band_new, key_up, key_abort, tx_drop, drain_done;
  logic [CNT_W-1:0] value;
  function automatic logic one_hot(input logic [BAND_W-1:0] v);
    return $countones(v) == 1;
  endfunction
  always_comb begin
    band_ok = one_hot(sif.bandReq);
    band_new = state == RX_IDLE && band_ok && sif.bandReq != sif.bandSelect;
    key_up = state == RX_IDLE && !band_new && sif.txReq && sif.bandSelect != '0 && !sif.bandFault;
    key_abort = state == TX_KEYUP && !sif.txReq;
    tx_drop = state == TX_ON && !sif.txReq;
    drain_done = state == RF_DRAIN && expired;
    load = band_new | key_up | key_abort | tx_drop | drain_done;
    value = band_new ? CNT_W'(BAND_SETTLE_CYC - 1) : tx_drop ? CNT_W'(RF_DRAIN_CYC - 1) : CNT_W'(PIN_SETTLE_CYC - 1);
  end
  settle_timer #(.CNT_W(CNT_W)) timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value(value),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      sif.bandSelect <= '0;
      sif.txEnable <= 1'b0;
      sif.ncoEnable <= 1'b0;
      sif.busy <= 1'b0;
      sif.txActive <= 1'b0;
      sif.bandFault <= 1'b0;
    end else begin
      sif.bandFault <= !band_ok;
      case (state)
        RX_IDLE:
          if (band_new) begin
            sif.bandSelect <= sif.bandReq;
            sif.busy <= 1'b1;
            state <= BAND_SETTLE;
          end else if (key_up) begin
            sif.txEnable <= 1'b1;
            sif.busy <= 1'b1;
            state <= TX_KEYUP;
          end
        BAND_SETTLE:
          if (expired) begin
            sif.busy <= 1'b0;
            state <= RX_IDLE;
          end
        TX_KEYUP:
          if (key_abort) state <= TX_KEYDOWN;
          else if (expired) begin
            sif.txActive <= 1'b1;
            state <= TX_ON;
          end
        TX_ON: begin
          sif.ncoEnable <= sif.txReq & sif.ncoEnableReq;
          if (tx_drop) begin
            sif.txActive <= 1'b0;
            state <= RF_DRAIN;
          end
        end
        RF_DRAIN:
          if (expired) begin
            sif.txEnable <= 1'b0;
            state <= TX_KEYDOWN;
          end
        TX_KEYDOWN:
          if (expired) begin
            sif.txEnable <= 1'b0;
            sif.busy <= 1'b0;
            state <= RX_IDLE;
          end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_rx_sequencer.sv
// tb_tx_rx_sequencer: directed and random checks of tx_rx_sequencer against a timestamp-based model
module tb_tx_rx_sequencer;
  localparam int BAND_N = 1000, PIN_N = 500, DRAIN_N = 200;
  localparam int P_IDLE = 0, P_BAND = 1, P_UP = 2, P_ON = 3, P_DRAIN = 4, P_DOWN = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  int cyc = 0, ph = P_IDLE, t_end = 0;
  logic [7:0] m_band = '0;
  logic m_tx = 1'b0, m_nco = 1'b0, m_fault = 1'b0;
  logic [12:0] dv, mv;
  tx_rx_sequencer_if sif();
  tx_rx_sequencer dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );
  always #5 clk = ~clk;
  assign dv = {sif.bandSelect, sif.txEnable, sif.ncoEnable, sif.busy, sif.txActive, sif.bandFault};
  assign mv = {m_band, m_tx, m_nco, ph != P_IDLE, ph == P_ON, m_fault};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic t, input logic [7:0] b, input logic n, input logic r);
    cyc++;
    if (r) begin
      ph = P_IDLE;
      m_band = '0;
      m_tx = 1'b0;
      m_nco = 1'b0;
      m_fault = 1'b0;
      return;
    end
    case (ph)
      P_IDLE:
        if ($countones(b) == 1 && b != m_band) begin
          m_band = b;
          ph = P_BAND;
          t_end = cyc + BAND_N;
        end else if (t && m_band != 0 && !m_fault) begin
          m_tx = 1'b1;
          ph = P_UP;
          t_end = cyc + PIN_N;
        end
      P_BAND: if (cyc == t_end) ph = P_IDLE;
      P_UP:
        if (!t) begin
          ph = P_DOWN;
          t_end = cyc + PIN_N;
        end else if (cyc == t_end) ph = P_ON;
      P_ON:
        if (!t) begin
          m_nco = 1'b0;
          ph = P_DRAIN;
          t_end = cyc + DRAIN_N;
        end else m_nco = n;
      P_DRAIN:
        if (cyc == t_end) begin
          m_tx = 1'b0;
          ph = P_DOWN;
          t_end = cyc + PIN_N;
        end
      default:
        if (cyc == t_end) begin
          m_tx = 1'b0;
          ph = P_IDLE;
        end
    endcase
    m_fault = $countones(b) != 1;
  endfunction
  task automatic step(input logic t, input logic [7:0] b, input logic n, input logic r);
    @(negedge clk);
    sif.txReq = t;
    sif.bandReq = b;
    sif.ncoEnableReq = n;
    rst = r;
    @(posedge clk);
    model(t, b, n, r);
    #1;
    chk("cycle", {19'd0, dv}, {19'd0, mv});
    if (sif.ncoEnable) chk("nco_inv", {30'd0, sif.txEnable, sif.txActive}, 32'd3);
  endtask
  initial begin
    int n, len;
    logic t, rr, nco_seen;
    logic [7:0] b;
    sif.txReq = 1'b0;
    sif.bandReq = '0;
    sif.ncoEnableReq = 1'b0;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("reset", {19'd0, dv}, 32'd0);
    step(0, 8'h04, 0, 0);
    chk("band_load", sif.bandSelect, 8'h04);
    n = 0;
    while (sif.busy && n < 2000) begin
      n++;
      step(0, 8'h04, 0, 0);
    end
    chk("band_busy_len", n, 1000);
    step(1, 8'h04, 1, 0);
    chk("tx_en_lat", sif.txEnable, 1);
    n = 1;
    while (!sif.ncoEnable && n < 1000) begin
      n++;
      step(1, 8'h04, 1, 0);
    end
    chk("nco_lat", n, 502);
    chk("tx_active", sif.txActive, 1);
    repeat (5) step(1, 8'h04, 1, 0);
    step(0, 8'h04, 1, 0);
    chk("nco_off", sif.ncoEnable, 0);
    n = 1;
    while (sif.txEnable && n < 1000) begin
      n++;
      step(0, 8'h04, 1, 0);
    end
    chk("tx_off_lat", n, 201);
    while (sif.busy && n < 2000) begin
      n++;
      step(0, 8'h04, 0, 0);
    end
    chk("busy_off_lat", n, 701);
    nco_seen = 1'b0;
    repeat (100) begin
      step(1, 8'h04, 1, 0);
      nco_seen |= sif.ncoEnable;
    end
    n = 0;
    step(0, 8'h04, 1, 0);
    while (sif.txEnable && n < 1000) begin
      n++;
      step(0, 8'h04, 1, 0);
      nco_seen |= sif.ncoEnable;
    end
    chk("abort_keydown", n, 500);
    chk("abort_nco", nco_seen, 0);
    chk("abort_idle", sif.busy, 0);
    step(0, 8'h06, 0, 0);
    chk("fault", sif.bandFault, 1);
    repeat (20) step(1, 8'h06, 0, 0);
    chk("fault_tx", sif.txEnable, 0);
    chk("fault_band", sif.bandSelect, 8'h04);
    n = 0;
    while (!sif.txActive && n < 600) begin
      n++;
      step(1, 8'h04, 1, 0);
    end
    repeat (10) step(1, 8'h10, 1, 0);
    chk("on_band_hold", sif.bandSelect, 8'h04);
    n = 0;
    while (sif.bandSelect != 8'h10 && n < 2000) begin
      n++;
      step(0, 8'h10, 0, 0);
    end
    chk("band_after_tx", sif.bandSelect, 8'h10);
    chk("band_after_busy", {sif.busy, sif.txEnable}, 2'b10);
    n = 0;
    while (sif.busy && n < 1100) begin
      n++;
      step(0, 8'h10, 0, 0);
    end
    n = 0;
    while (!sif.txActive && n < 600) begin
      n++;
      step(1, 8'h10, 1, 0);
    end
    step(1, 8'h10, 1, 0);
    chk("pre_rst_nco", sif.ncoEnable, 1);
    step(1, 8'h10, 1, 1);
    chk("rst_in_on", {sif.bandSelect, sif.txEnable, sif.ncoEnable, sif.busy}, 0);
    step(0, 8'h10, 0, 0);
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 600);
      t = $urandom_range(0, 3) != 0;
      rr = $urandom_range(0, 19) == 0;
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01 << $urandom_range(0, 7);
      for (int k = 0; k < len; k++) step(t, b, 1'($urandom_range(0, 1)), rr && k < 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
